csr_regmap_responder: RTL and testbench

Register-map responder for the REG_MAP end of `bus_interface`, so the APB4 slave bridge has a concrete target. It accepts single-cycle `bus_req` pulses from the bridge and decodes the address. It then executes bit-enabled writes or reads against a small CSR file: general-purpose registers, a read-only ID, a W1C event status, and a saturating event counter. It returns `bus_ready`, `bus_rd_data` and `bus_err` after a fixed, parameterised latency.

---
 rtl/csr_regmap_pkg.sv | 24 ++
 rtl/csr_sat_counter.sv | 29 ++
 rtl/csr_regmap_responder.sv | 192 +++++++++++++++++++
 tb/tb_csr_regmap_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/csr_regmap_pkg.sv
// Shared address map, status bit positions and FSM encoding for the CSR
// register-map responder.
package csr_regmap_pkg;

    localparam logic [10:0] GPR_BASE     = 11'h000;
    localparam logic [10:0] ID_OFFS      = 11'h100;
    localparam logic [10:0] STATUS_OFFS  = 11'h104;
    localparam logic [10:0] EVT_CNT_OFFS = 11'h108;

    localparam int unsigned PROTO_ERR_BIT = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    function automatic logic [31:0] merge_bits(input logic [31:0] old_v,
                                               input logic [31:0] wdata,
                                               input logic [31:0] biten);
        return (old_v & ~biten) | (wdata & biten);
    endfunction

endpackage

// File: rtl/csr_sat_counter.sv
// Saturating up-counter; clear takes priority over increment.
module csr_sat_counter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] count
);

    logic [DATA_WIDTH-1:0] count_r;

    // Count register: reset/clear to zero, otherwise increment until all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {DATA_WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {DATA_WIDTH{1'b0}};
        end else if (inc && (count_r != {DATA_WIDTH{1'b1}})) begin
            count_r <= count_r + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/csr_regmap_responder.sv
// Bus target with a small CSR file (GPRs, ID, W1C status, event counter) that
// answers each single-cycle request after a fixed, registered latency.
module csr_regmap_responder
    import csr_regmap_pkg::*;
#(
    parameter int unsigned        DATA_WIDTH   = 32,
    parameter int unsigned        ADDR_WIDTH   = 11,
    parameter int unsigned        NUM_REGS     = 8,
    parameter int unsigned        RESP_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE  = 32'hC5A0_0001,
    parameter int unsigned        EVT_WIDTH    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           bus_req,
    input  logic                           bus_req_is_wr,
    input  logic [ADDR_WIDTH-1:0]          bus_addr,
    input  logic [DATA_WIDTH-1:0]          bus_wr_data,
    input  logic [DATA_WIDTH-1:0]          bus_wr_biten,
    output logic                           bus_ready,
    output logic [DATA_WIDTH-1:0]          bus_rd_data,
    output logic                           bus_err,
    input  logic [EVT_WIDTH-1:0]           hw_event,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic                           irq
);

    localparam int unsigned           WIDX_W = ADDR_WIDTH - 2;
    localparam logic [DATA_WIDTH-1:0] ZERO   = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONE    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] STATUS_MASK =
        (ONE << PROTO_ERR_BIT) | ((ONE << EVT_WIDTH) - ONE);

    resp_state_e           state_r;
    logic [3:0]            wait_cnt_r;
    logic [DATA_WIDTH-1:0] gpr_r [NUM_REGS];
    logic [DATA_WIDTH-1:0] status_r, status_next_s, status_set_s, status_clr_s;
    logic [DATA_WIDTH-1:0] evt_cnt_s, gpr_rd_s, rd_data_s;
    logic [DATA_WIDTH-1:0] resp_data_r, bus_rd_data_r;
    logic                  resp_err_r, bus_ready_r, bus_err_r, irq_r;
    logic [ADDR_WIDTH-1:0] gpr_offs_s;
    logic [WIDX_W-1:0]     word_idx_s;
    logic [NUM_REGS-1:0]   gpr_sel_s;
    logic                  aligned_s, gpr_hit_s, id_hit_s, status_hit_s, cnt_hit_s;
    logic                  err_s, accept_s, wr_accept_s, proto_viol_s, cnt_clr_s;

    // Address decode, read mux and next-state of the W1C status register.
    always_comb begin
        gpr_offs_s   = bus_addr - ADDR_WIDTH'(GPR_BASE);
        word_idx_s   = gpr_offs_s[ADDR_WIDTH-1:2];
        aligned_s    = (bus_addr[1:0] == 2'b00);
        gpr_hit_s    = aligned_s && (word_idx_s < WIDX_W'(NUM_REGS));
        id_hit_s     = aligned_s && (bus_addr == ADDR_WIDTH'(ID_OFFS));
        status_hit_s = aligned_s && (bus_addr == ADDR_WIDTH'(STATUS_OFFS));
        cnt_hit_s    = aligned_s && (bus_addr == ADDR_WIDTH'(EVT_CNT_OFFS));
        err_s        = !(gpr_hit_s || id_hit_s || status_hit_s || cnt_hit_s)
                       || (id_hit_s && bus_req_is_wr);

        gpr_sel_s = {NUM_REGS{1'b0}};
        gpr_rd_s  = ZERO;
        for (int i = 0; i < NUM_REGS; i++) begin
            gpr_sel_s[i] = gpr_hit_s && (word_idx_s == WIDX_W'(i));
            gpr_rd_s     = gpr_rd_s | (gpr_r[i] & {DATA_WIDTH{gpr_sel_s[i]}});
        end

        if (err_s) begin
            rd_data_s = ZERO;
        end else if (gpr_hit_s) begin
            rd_data_s = gpr_rd_s;
        end else if (id_hit_s) begin
            rd_data_s = ID_VALUE;
        end else if (status_hit_s) begin
            rd_data_s = status_r & STATUS_MASK;
        end else if (cnt_hit_s) begin
            rd_data_s = evt_cnt_s;
        end else begin
            rd_data_s = ZERO;
        end

        // Requests outside IDLE are dropped and only flag PROTO_ERR.
        accept_s     = bus_req && (state_r == IDLE) && !err_s;
        wr_accept_s  = accept_s && bus_req_is_wr;
        proto_viol_s = bus_req && (state_r != IDLE);
        cnt_clr_s    = wr_accept_s && cnt_hit_s && (|bus_wr_biten);

        status_clr_s  = (wr_accept_s && status_hit_s) ? (bus_wr_data & bus_wr_biten) : ZERO;
        status_set_s  = (proto_viol_s ? (ONE << PROTO_ERR_BIT) : ZERO)
                        | {{(DATA_WIDTH-EVT_WIDTH){1'b0}}, hw_event};
        // Hardware set is OR-ed after the clear so it wins on a collision.
        status_next_s = ((status_r & ~status_clr_s) | status_set_s) & STATUS_MASK;
    end

    // General-purpose registers with bit-enabled writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr_r[i] <= ZERO;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_accept_s && gpr_sel_s[i]) begin
                    gpr_r[i] <= merge_bits(gpr_r[i], bus_wr_data, bus_wr_biten);
                end
            end
        end
    end

    // Status register and its registered interrupt summary.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_r <= ZERO;
            irq_r    <= 1'b0;
        end else begin
            status_r <= status_next_s;
            irq_r    <= |status_r;
        end
    end

    csr_sat_counter #(.DATA_WIDTH(DATA_WIDTH)) u_evt_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (|hw_event),
        .clr   (cnt_clr_s),
        .count (evt_cnt_s)
    );

    // Response FSM: capture at request, wait out the latency, pulse ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            wait_cnt_r    <= 4'd0;
            resp_data_r   <= ZERO;
            resp_err_r    <= 1'b0;
            bus_ready_r   <= 1'b0;
            bus_rd_data_r <= ZERO;
            bus_err_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    bus_ready_r   <= 1'b0;
                    bus_rd_data_r <= ZERO;
                    bus_err_r     <= 1'b0;
                    if (bus_req) begin
                        resp_data_r <= rd_data_s;
                        resp_err_r  <= err_s;
                        if (RESP_LATENCY == 1) begin
                            state_r       <= RESP;
                            bus_ready_r   <= 1'b1;
                            bus_rd_data_r <= rd_data_s;
                            bus_err_r     <= err_s;
                        end else begin
                            state_r    <= WAIT;
                            wait_cnt_r <= 4'(RESP_LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_r == 4'd1) begin
                        state_r       <= RESP;
                        bus_ready_r   <= 1'b1;
                        bus_rd_data_r <= resp_data_r;
                        bus_err_r     <= resp_err_r;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    state_r       <= IDLE;
                    bus_ready_r   <= 1'b0;
                    bus_rd_data_r <= ZERO;
                    bus_err_r     <= 1'b0;
                end
                default: begin
                    state_r       <= IDLE;
                    bus_ready_r   <= 1'b0;
                    bus_rd_data_r <= ZERO;
                    bus_err_r     <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = gpr_r[g];
    end

    assign bus_ready   = bus_ready_r;
    assign bus_rd_data = bus_rd_data_r;
    assign bus_err     = bus_err_r;
    assign irq         = irq_r;

endmodule

// File: tb/tb_csr_regmap_responder.sv
// Directed bench: instance 0 uses RESP_LATENCY=1, instance 1 uses RESP_LATENCY=3.
module tb_csr_regmap_responder;

    logic         clk = 1'b0;
    logic         rst    [2];
    logic         req    [2];
    logic         is_wr  [2];
    logic [10:0]  addr   [2];
    logic [31:0]  wdata  [2];
    logic [31:0]  biten  [2];
    logic [7:0]   ev     [2];
    logic         ready  [2];
    logic [31:0]  rdata  [2];
    logic         err    [2];
    logic [255:0] regq   [2];
    logic         irq    [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    csr_regmap_responder #(.RESP_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst[0]), .bus_req(req[0]), .bus_req_is_wr(is_wr[0]),
        .bus_addr(addr[0]), .bus_wr_data(wdata[0]), .bus_wr_biten(biten[0]),
        .bus_ready(ready[0]), .bus_rd_data(rdata[0]), .bus_err(err[0]),
        .hw_event(ev[0]), .reg_q(regq[0]), .irq(irq[0])
    );

    csr_regmap_responder #(.RESP_LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst[1]), .bus_req(req[1]), .bus_req_is_wr(is_wr[1]),
        .bus_addr(addr[1]), .bus_wr_data(wdata[1]), .bus_wr_biten(biten[1]),
        .bus_ready(ready[1]), .bus_rd_data(rdata[1]), .bus_err(err[1]),
        .hw_event(ev[1]), .reg_q(regq[1]), .irq(irq[1])
    );

    // One request on instance d (events driven alongside), then wait for ready.
    task automatic bus_txn(input int d, input logic wr, input logic [10:0] a,
                           input logic [31:0] wd, input logic [31:0] be, input logic [7:0] e,
                           output logic [31:0] rd, output logic er, output int lat);
        @(posedge clk); #1;
        req[d] = 1'b1; is_wr[d] = wr; addr[d] = a; wdata[d] = wd; biten[d] = be; ev[d] = e;
        @(posedge clk); #1;
        req[d] = 1'b0; is_wr[d] = 1'b0; wdata[d] = 32'h0; biten[d] = 32'h0; ev[d] = 8'h00;
        lat = 1;
        while (ready[d] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata[d];
        er = err[d];
        n_checks++; if (ready[d] !== 1'b1) begin n_fail++; $display("FAIL txn_timeout: dut %0d addr %h no bus_ready within %0d cycles", d, a, lat); end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; is_wr[d] = 1'b0; addr[d] = 11'h0;
            wdata[d] = 32'h0; biten[d] = 32'h0; ev[d] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (ready[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ready: dut %0d got %b want 0", d, ready[d]); end
            n_checks++; if (rdata[d] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: dut %0d got %h want 0", d, rdata[d]); end
            n_checks++; if (irq[d] !== 1'b0) begin n_fail++; $display("FAIL reset_irq: dut %0d got %b want 0", d, irq[d]); end
            n_checks++; if (regq[d] !== 256'h0) begin n_fail++; $display("FAIL reset_regq: dut %0d got %h want 0", d, regq[d]); end
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
    endtask

    task automatic test_reads();
        logic [31:0] rd; logic er; int lat;
        bus_txn(0, 1'b0, 11'h000, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL rd_gpr0_lat: got %0d want 1", lat); end
        n_checks++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL rd_gpr0: got %h err %b want 0 err 0", rd, er); end
        bus_txn(0, 1'b0, 11'h100, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL rd_id_lat: got %0d want 1", lat); end
        n_checks++; if (rd !== 32'hC5A0_0001 || er !== 1'b0) begin n_fail++; $display("FAIL rd_id: got %h err %b want c5a00001 err 0", rd, er); end
        bus_txn(0, 1'b0, 11'h104, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL rd_status0: got %h err %b want 0 err 0", rd, er); end
    endtask

    task automatic test_gpr_write();
        logic [31:0] rd; logic er; int lat;
        bus_txn(0, 1'b1, 11'h004, 32'hFFFF_FFFF, 32'h0000_FF00, 8'h00, rd, er, lat);
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_gpr1_err: got %b want 0", er); end
        bus_txn(0, 1'b0, 11'h004, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (rd !== 32'h0000_FF00) begin n_fail++; $display("FAIL rd_gpr1: got %h want 0000ff00", rd); end
        n_checks++; if (regq[0][63:32] !== 32'h0000_FF00) begin n_fail++; $display("FAIL regq_gpr1: got %h want 0000ff00", regq[0][63:32]); end
        n_checks++; if (regq[0][31:0] !== 32'h0) begin n_fail++; $display("FAIL regq_gpr0: got %h want 0", regq[0][31:0]); end
        bus_txn(0, 1'b1, 11'h01C, 32'h1234_5678, 32'hFFFF_0000, 8'h00, rd, er, lat);
        bus_txn(0, 1'b0, 11'h01C, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (rd !== 32'h1234_0000) begin n_fail++; $display("FAIL rd_gpr7: got %h want 12340000", rd); end
        n_checks++; if (regq[0][255:224] !== 32'h1234_0000) begin n_fail++; $display("FAIL regq_gpr7: got %h want 12340000", regq[0][255:224]); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        bus_txn(0, 1'b0, 11'h002, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_misaligned: got %h err %b want 0 err 1", rd, er); end
        bus_txn(0, 1'b0, 11'h0FC, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_gpr_oob: got %h err %b want 0 err 1", rd, er); end
        bus_txn(0, 1'b1, 11'h100, 32'h0, 32'hFFFF_FFFF, 8'h00, rd, er, lat);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_wr_id: got %h err %b want 0 err 1", rd, er); end
        bus_txn(0, 1'b0, 11'h100, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (rd !== 32'hC5A0_0001 || er !== 1'b0) begin n_fail++; $display("FAIL id_unchanged: got %h err %b want c5a00001 err 0", rd, er); end
        bus_txn(0, 1'b1, 11'h006, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, rd, er, lat);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_wr_misaligned: got %b want 1", er); end
        n_checks++; if (regq[0][63:32] !== 32'h0000_FF00) begin n_fail++; $display("FAIL gpr1_after_err: got %h want 0000ff00", regq[0][63:32]); end
        bus_txn(0, 1'b0, 11'h10C, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_unmapped: got %h err %b want 0 err 1", rd, er); end
    endtask

    task automatic test_events();
        logic [31:0] rd; logic er; int lat;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1; ev[0] = 8'h05;
            @(posedge clk); #1; ev[0] = 8'h00;
        end
        bus_txn(0, 1'b0, 11'h108, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (rd !== 32'd2) begin n_fail++; $display("FAIL evt_cnt_2: got %h want 2", rd); end
        bus_txn(0, 1'b0, 11'h104, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL status_5: got %h want 5", rd); end
        n_checks++; if (irq[0] !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", irq[0]); end
        bus_txn(0, 1'b1, 11'h104, 32'h1, 32'hFFFF_FFFF, 8'h00, rd, er, lat);
        bus_txn(0, 1'b0, 11'h104, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (rd !== 32'h4) begin n_fail++; $display("FAIL status_w1c: got %h want 4", rd); end
        n_checks++; if (irq[0] !== 1'b1) begin n_fail++; $display("FAIL irq_still: got %b want 1", irq[0]); end
        bus_txn(0, 1'b1, 11'h104, 32'h4, 32'hFFFF_FFFF, 8'h04, rd, er, lat);
        bus_txn(0, 1'b0, 11'h104, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (rd !== 32'h4) begin n_fail++; $display("FAIL status_set_wins: got %h want 4", rd); end
        bus_txn(0, 1'b0, 11'h108, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (rd !== 32'd3) begin n_fail++; $display("FAIL evt_cnt_3: got %h want 3", rd); end
        bus_txn(0, 1'b1, 11'h104, 32'h4, 32'hFFFF_FFFF, 8'h00, rd, er, lat);
        bus_txn(0, 1'b0, 11'h104, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL status_clear: got %h want 0", rd); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", irq[0]); end
        bus_txn(0, 1'b1, 11'h108, 32'h0, 32'h0000_0001, 8'h01, rd, er, lat);
        bus_txn(0, 1'b0, 11'h108, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL evt_cnt_clr_wins: got %h want 0", rd); end
        bus_txn(0, 1'b0, 11'h104, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL status_bit0: got %h want 1", rd); end
    endtask

    task automatic test_latency3();
        logic [31:0] rd; logic er; int lat; int extra;
        bus_txn(1, 1'b1, 11'h000, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 8'h00, rd, er, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL lat3_wr: got %0d want 3", lat); end
        n_checks++; if (regq[1][31:0] !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL lat3_gpr0: got %h want a5a5a5a5", regq[1][31:0]); end
        @(posedge clk); #1;
        req[1] = 1'b1; is_wr[1] = 1'b0; addr[1] = 11'h100;
        @(posedge clk); #1;
        n_checks++; if (ready[1] !== 1'b0) begin n_fail++; $display("FAIL lat3_c1: got %b want 0", ready[1]); end
        req[1] = 1'b1; is_wr[1] = 1'b1; addr[1] = 11'h000; wdata[1] = 32'h0; biten[1] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        req[1] = 1'b0; is_wr[1] = 1'b0; biten[1] = 32'h0;
        n_checks++; if (ready[1] !== 1'b0) begin n_fail++; $display("FAIL lat3_c2: got %b want 0", ready[1]); end
        @(posedge clk); #1;
        n_checks++; if (ready[1] !== 1'b1 || rdata[1] !== 32'hC5A0_0001) begin n_fail++; $display("FAIL lat3_c3: got ready %b data %h want 1 c5a00001", ready[1], rdata[1]); end
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ready[1] === 1'b1) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL lat3_no_second: got %0d responses want 0", extra); end
        n_checks++; if (regq[1][31:0] !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL lat3_no_write: got %h want a5a5a5a5", regq[1][31:0]); end
        bus_txn(1, 1'b0, 11'h104, 32'h0, 32'h0, 8'h00, rd, er, lat);
        n_checks++; if (rd !== 32'h8000_0000) begin n_fail++; $display("FAIL lat3_proto_err: got %h want 80000000", rd); end
        n_checks++; if (irq[1] !== 1'b1) begin n_fail++; $display("FAIL lat3_irq: got %b want 1", irq[1]); end
    endtask

    task automatic test_reset_midflight();
        int extra;
        @(posedge clk); #1;
        req[1] = 1'b1; is_wr[1] = 1'b0; addr[1] = 11'h000;
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(posedge clk); #1;
        rst[1] = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (ready[1] !== 1'b0 || rdata[1] !== 32'h0 || err[1] !== 1'b0) begin n_fail++; $display("FAIL rstmid_resp: got ready %b data %h err %b want 0 0 0", ready[1], rdata[1], err[1]); end
        n_checks++; if (irq[1] !== 1'b0) begin n_fail++; $display("FAIL rstmid_irq: got %b want 0", irq[1]); end
        n_checks++; if (regq[1] !== 256'h0) begin n_fail++; $display("FAIL rstmid_regq: got %h want 0", regq[1]); end
        rst[1] = 1'b0;
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (ready[1] === 1'b1) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL rstmid_dropped: got %0d responses want 0", extra); end
    endtask

    initial begin
        test_reset();
        test_reads();
        test_gpr_write();
        test_errors();
        test_events();
        test_latency3();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
